boid_plotter: RTL and testbench
===============================

BOID_PLOTTER -- requirements
Module: boid_plotter

Interface
REQ-001 SHALL have parameter BOID_COLOR, default 8'hFF, the colour index written at the boid position.
REQ-002 SHALL have parameter BG_COLOR, default 8'h00, the colour index written when erasing the old position.
REQ-003 SHALL have port clock, input, 1, the 50 MHz system clock.
REQ-004 SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-005 SHALL have port x_loc, input, 10, the boid x coordinate from the boid processing stage.
REQ-006 SHALL have port y_loc, input, 9, the boid y coordinate.
REQ-007 SHALL have port loc_valid, input, 1, which marks x_loc/y_loc as valid.
REQ-008 SHALL have port loc_ready, output, 1, which signals that the block can accept a location.
REQ-009 SHALL have port frame_start, input, 1, a one-cycle pulse at the start of vertical blanking.
REQ-010 SHALL have port wr_en, output, 1, the frame-buffer write strobe.
REQ-011 SHALL have port wr_addr, output, 19, the frame-buffer pixel address.
REQ-012 SHALL have port wr_data, output, 8, the frame-buffer colour index.
REQ-013 SHALL have port busy, output, 1, which is high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, CALC, WAIT_FRAME, ERASE and DRAW.
REQ-015 SHALL drive loc_ready=1 only in IDLE, and SHALL accept a location on loc_valid && loc_ready.
REQ-016 SHALL, on acceptance, clamp x to 639 if x_loc>639 and y to 479 if y_loc>479, then move to CALC.
REQ-017 SHALL, in CALC, register addr = x + 640*y, computed as x + (y<<9) + (y<<7) in 19 bits, then move to WAIT_FRAME after exactly 1 cycle.
REQ-018 SHALL, when frame_start is high in CALC, set a pending flag so the pulse is not lost.
REQ-019 SHALL, in WAIT_FRAME, move to ERASE on frame_start or a set pending flag, and SHALL clear the pending flag when it does.
REQ-020 SHALL ignore frame_start in IDLE, ERASE and DRAW.
REQ-021 SHALL, in ERASE, assert wr_en for 1 cycle with wr_addr=prev_addr and wr_data=BG_COLOR, but only when prev_valid=1; SHALL always move to DRAW next.
REQ-022 SHALL, in DRAW, assert wr_en for 1 cycle with wr_addr=addr and wr_data=BOID_COLOR, then set prev_addr=addr and prev_valid=1 and return to IDLE.
REQ-023 SHALL hold wr_en=0 in all other states, and SHALL keep wr_addr/wr_data registered (no combinational path from inputs).
REQ-024 SHALL produce, when frame_start is already high on entry to WAIT_FRAME, the erase write exactly 1 cycle after frame_start and the draw write 2 cycles after it.
REQ-025 SHALL still perform the erase write when the same location is accepted twice, so ERASE then DRAW both target the same address.

Reset
REQ-026 SHALL, on reset assertion, immediately set state=IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, prev_valid=0, pending=0 and prev_addr=0.
REQ-027 SHALL drive loc_ready=1 in the first cycle after reset deasserts.
REQ-028 SHALL abort an ERASE or DRAW in progress on reset without a further write; the pixel may be left partially drawn.

Configuration
REQ-029 SHALL, with BOID_PLOTTER_TRAIL_EN defined, skip ERASE so that WAIT_FRAME moves directly to DRAW and old positions remain as trails.
REQ-030 SHALL, without BOID_PLOTTER_TRAIL_EN, behave as in REQ-021.

Structure
REQ-031 SHALL place SCREEN_W=640, SCREEN_H=480, ADDR_W=19, COLOR_W=8 and the state enumeration in the shared package boid_pkg.
REQ-032 SHALL perform the clamp and the registered x+640*y computation in a sub-module named pixel_addr_calc, which is reusable by the boid processing stage.

Verification
REQ-033 SHALL cover: reset, then (100,100) valid, then frame_start -> single write, addr 64100, data 8'hFF, with no erase write.
REQ-034 SHALL cover: after REQ-033, (0,0) and frame_start -> write addr 64100 data 8'h00, then write addr 0 data 8'hFF on the next cycle.
REQ-035 SHALL cover: (700,500) -> draw addr 307199, which equals the draw address for (639,479).
REQ-036 SHALL cover: frame_start pulsed during CALC and no further pulse -> draw still occurs, within 3 cycles of entering WAIT_FRAME.
REQ-037 SHALL cover: reset asserted during ERASE -> wr_en=0 at once; the next location causes no erase write.
REQ-038 SHALL cover: with BOID_PLOTTER_TRAIL_EN, two locations -> exactly 2 writes in total, both with data 8'hFF.

Source files
------------

// File: rtl/boid_pkg.sv
// Shared screen geometry, bus widths and plotter state encoding for the boid pipeline.
package boid_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int ADDR_W   = 19;
   localparam int COLOR_W  = 8;
   localparam int X_W      = 10;
   localparam int Y_W      = 9;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      WAIT_FRAME,
      ERASE,
      DRAW
   } state_t;

endpackage

// File: rtl/pixel_addr_calc.sv
// Clamps a boid coordinate to the visible screen and turns it into a linear
// frame-buffer address (x + 640*y), one register stage per step.
module pixel_addr_calc
   import boid_pkg::*;
(
   input  logic              clock,
   input  logic              load,
   input  logic              calc,
   input  logic [X_W-1:0]    x_loc,
   input  logic [Y_W-1:0]    y_loc,
   output logic [ADDR_W-1:0] addr
);

   logic [X_W-1:0]    x_p0;
   logic [Y_W-1:0]    y_p0;
   logic [ADDR_W-1:0] addr_p1;

   function automatic logic [X_W-1:0] sat_x(input logic [X_W-1:0] x);
      return (x > X_W'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : x;
   endfunction

   function automatic logic [Y_W-1:0] sat_y(input logic [Y_W-1:0] y);
      return (y > Y_W'(SCREEN_H - 1)) ? Y_W'(SCREEN_H - 1) : y;
   endfunction

   // p0: clamped coordinate captured on acceptance
   always_ff @(posedge clock) begin
      if (load) begin
         x_p0 <= sat_x(x_loc);
         y_p0 <= sat_y(y_loc);
      end
   end

   // p1: 640*y built from two shifts so no multiplier is needed
   always_ff @(posedge clock) begin
      if (calc) begin
         addr_p1 <= ADDR_W'(x_p0) + (ADDR_W'(y_p0) << 9) + (ADDR_W'(y_p0) << 7);
      end
   end

   assign addr = addr_p1;

endmodule

// File: rtl/boid_plotter.sv
// Plots one boid per frame: erases its previous pixel, then draws the new one during blanking.
// Define BOID_PLOTTER_TRAIL_EN to skip the erase and leave trails behind.
module boid_plotter
   import boid_pkg::*;
#(
   parameter logic [COLOR_W-1:0] BOID_COLOR = 8'hFF,
   parameter logic [COLOR_W-1:0] BG_COLOR   = 8'h00
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [X_W-1:0]     x_loc,
   input  logic [Y_W-1:0]     y_loc,
   input  logic               loc_valid,
   output logic               loc_ready,
   input  logic               frame_start,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [COLOR_W-1:0] wr_data,
   output logic               busy
);

   state_t            state, state_nxt;
   logic              pending, prev_valid, accept, go;
   logic [ADDR_W-1:0] addr, prev_addr;

   assign loc_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = loc_valid && loc_ready;

   pixel_addr_calc u_addr_calc (
      .clock (clock),
      .load  (accept),
      .calc  (state == CALC),
      .x_loc (x_loc),
      .y_loc (y_loc),
      .addr  (addr)
   );

   always_comb begin
      state_nxt = state;
      go        = 1'b0;
      case (state)
         IDLE:       if (accept) state_nxt = CALC;
         CALC:       state_nxt = WAIT_FRAME;
         WAIT_FRAME: begin
            if (frame_start || pending) begin
               go = 1'b1;
`ifdef BOID_PLOTTER_TRAIL_EN
               state_nxt = DRAW;
`else
               state_nxt = ERASE;
`endif
            end
         end
         ERASE:      state_nxt = DRAW;
         DRAW:       state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Write strobes are registered from the next state so each write lines up with its state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         pending    <= 1'b0;
         prev_valid <= 1'b0;
         prev_addr  <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         state <= state_nxt;
         if (state == CALC && frame_start) pending <= 1'b1;
         else if (go)                      pending <= 1'b0;
         if (state == DRAW) begin
            prev_addr  <= addr;
            prev_valid <= 1'b1;
         end
         wr_en <= 1'b0;
         if (state_nxt == ERASE) begin
            wr_en   <= prev_valid;
            wr_addr <= prev_addr;
            wr_data <= BG_COLOR;
         end else if (state_nxt == DRAW) begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= BOID_COLOR;
         end
      end
   end

endmodule

// File: tb/tb_boid_plotter.sv
// Scoreboard bench for boid_plotter: stimulus queues expected frame-buffer writes
// (address, colour, cycle), a monitor pops and compares every wr_en strobe.
module tb_boid_plotter;
   import boid_pkg::*;

`ifdef BOID_PLOTTER_TRAIL_EN
   localparam bit TRAIL = 1'b1;
`else
   localparam bit TRAIL = 1'b0;
`endif

   typedef struct {
      logic [18:0] addr;
      logic [7:0]  data;
      int          cyc;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  x_loc = '0;
   logic [8:0]  y_loc = '0;
   logic        loc_valid = 1'b0;
   logic        frame_start = 1'b0;
   logic        loc_ready, wr_en, busy;
   logic [18:0] wr_addr;
   logic [7:0]  wr_data;

   int  cyc = 0;
   int  n_vec = 0;
   int  n_miss = 0;
   bit  done = 1'b0;
   wr_t exp_q[$];

   boid_plotter #(.BOID_COLOR(8'hFF), .BG_COLOR(8'h00)) dut (
      .clock       (clock),
      .reset       (reset),
      .x_loc       (x_loc),
      .y_loc       (y_loc),
      .loc_valid   (loc_valid),
      .loc_ready   (loc_ready),
      .frame_start (frame_start),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy)
   );

   always #10 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [18:0] a, input logic [7:0] d, input int c);
      wr_t w;
      w.addr = a;
      w.data = d;
      w.cyc  = c;
      exp_q.push_back(w);
   endtask

   // Monitor: every write strobe must match the oldest queued expectation.
   initial begin
      wr_t w;
      forever begin
         @(negedge clock);
         if (done) break;
         if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write_addr", int'(wr_addr), -1);
            end else begin
               w = exp_q.pop_front();
               chk("write_addr", int'(wr_addr), int'(w.addr));
               chk("write_data", int'(wr_data), int'(w.data));
               chk("write_cycle", cyc, w.cyc);
            end
         end
      end
   end

   // Accept (x,y), then trigger the frame either during CALC (early) or after
   // idle_wait cycles of WAIT_FRAME; queue the erase (if any) and the draw.
   task automatic plot(input int x, input int y, input int a, input bit has_prev,
                       input int pa, input bit early, input int idle_wait);
      int base;
      chk("loc_ready_before", int'(loc_ready), 1);
      x_loc = 10'(x);
      y_loc = 9'(y);
      loc_valid = 1'b1;
      tick();
      loc_valid = 1'b0;
      chk("busy_in_calc", int'(busy), 1);
      if (early) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         base = cyc;
         if (!TRAIL && has_prev) push(19'(pa), 8'h00, base + 1);
         push(19'(a), 8'hFF, TRAIL ? base + 1 : base + 2);
      end else begin
         tick();
         repeat (idle_wait) tick();
         if (idle_wait > 0) chk("waiting_for_frame", int'(busy), 1);
         base = cyc;
         if (!TRAIL && has_prev) push(19'(pa), 8'h00, base + 1);
         push(19'(a), 8'hFF, TRAIL ? base + 1 : base + 2);
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
      end
      repeat (3) tick();
      chk("idle_after_draw", int'(busy), 0);
   endtask

   initial begin
      #5;
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_wr_addr", int'(wr_addr), 0);
      chk("rst_wr_data", int'(wr_data), 0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("ready_after_reset", int'(loc_ready), 1);

      // first boid: nothing to erase
      plot(100, 100, 64100, 1'b0, 0, 1'b0, 0);
      // move to origin: erase 64100, draw 0 on the next cycle
      plot(0, 0, 0, 1'b1, 64100, 1'b0, 0);
      // off-screen coordinates clamp to bottom-right corner
      plot(700, 500, 307199, 1'b1, 0, 1'b0, 0);
      // same location twice still erases before drawing
      plot(639, 479, 307199, 1'b1, 307199, 1'b0, 0);
      // frame pulse during CALC must not be lost
      plot(5, 2, 1285, 1'b1, 307199, 1'b1, 0);

      // frame pulse while IDLE is ignored; plot must wait for a real frame
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      plot(3, 1, 643, 1'b1, 1285, 1'b0, 4);

      // reset in the middle of the erase/draw sequence aborts the write at once
      x_loc = 10'd10;
      y_loc = 9'd0;
      loc_valid = 1'b1;
      tick();
      loc_valid = 1'b0;
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("write_in_progress", int'(wr_en), 1);
      reset = 1'b1;
      #1;
      chk("abort_wr_en", int'(wr_en), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_wr_addr", int'(wr_addr), 0);
      tick();
      reset = 1'b0;
      tick();
      chk("ready_after_abort", int'(loc_ready), 1);
      // previous position forgotten: draw only
      plot(1, 1, 641, 1'b0, 0, 1'b0, 0);

      repeat (4) tick();
      chk("queue_drained", exp_q.size(), 0);
      done = 1'b1;
      @(negedge clock);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
